// File: rtl/debug_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debug_ctrl_pkg
// Purpose  : Shared definitions for the UART debug controller: host command
//            opcodes, step sub-commands, dump status codes and the state
//            encodings of the controller and the dump serializer.
// Ports    : (package, none)
// Options  : DBG_RUN_TIMEOUT_EN (used by debug_ctrl_gen / serializer)
// Revision : 1.0 - initial release
// ============================================================================
package debug_ctrl_pkg;

    // Host command bytes decoded in IDLE
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_BRK  = 8'h04;

    // Sub-commands accepted while waiting for single steps
    localparam logic [7:0] STEP_GO   = 8'h01;
    localparam logic [7:0] STEP_EXIT = 8'h00;

    // Leading status byte of a dump (only sent with the watchdog enabled)
    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_TIMEOUT = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LD_LEN     = 4'd1,
        S_LD_BYTE    = 4'd2,
        S_LD_WRITE   = 4'd3,
        S_BRK_ADDR   = 4'd4,
        S_RUN        = 4'd5,
        S_STEP_WAIT  = 4'd6,
        S_STEP_PULSE = 4'd7,
        S_DUMP       = 4'd8
    } dbg_state_t;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_SEND = 2'd1,
        SER_WAIT = 2'd2
    } ser_state_t;

endpackage : debug_ctrl_pkg
`default_nettype wire

// File: rtl/debug_ctrl_gen_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debug_dump_serializer
// Purpose  : Captures a snapshot + cycle count on i_start and sends it byte by
//            byte (LSB first) to the UART transmitter, one byte per
//            is_tx_done handshake. os_done pulses after the last byte's
//            is_tx_done.
// Ports    : clk, rst              - clock, async active-high reset
//            i_start               - capture and begin a dump
//            i_snapshot, i_count   - payload captured on i_start
//            i_status              - leading status byte (watchdog build only)
//            is_tx_done            - transmitter finished a byte
//            o_tx_data, os_tx_start- byte and one-cycle start strobe
//            os_done               - one-cycle strobe, dump complete
// Options  : DBG_RUN_TIMEOUT_EN prepends i_status to every dump
// Revision : 1.0 - initial release
// ============================================================================
module debug_dump_serializer
    import debug_ctrl_pkg::*;
#(
    parameter int SNAP_BYTES = 320,
    parameter int CNT_W      = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_start,
    input  wire logic [SNAP_BYTES*8-1:0] i_snapshot,
    input  wire logic [CNT_W-1:0]        i_count,
    input  wire logic [7:0]              i_status,
    input  wire logic                    is_tx_done,
    output logic [7:0]                   o_tx_data,
    output logic                         os_tx_start,
    output logic                         os_done
);

`ifdef DBG_RUN_TIMEOUT_EN
    localparam int TOTAL = 1 + SNAP_BYTES + CNT_W / 8;
`else
    localparam int TOTAL = SNAP_BYTES + CNT_W / 8;
`endif
    localparam int IDX_W = $clog2(TOTAL + 1);

    ser_state_t          ser_q, ser_d;
    logic [TOTAL*8-1:0]  sh_q, sh_d;
    logic [IDX_W-1:0]    rem_q, rem_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                done_q, done_d;
    logic [TOTAL*8-1:0]  w_payload;

`ifdef DBG_RUN_TIMEOUT_EN
    assign w_payload = {i_count, i_snapshot, i_status};
`else
    assign w_payload = {i_count, i_snapshot};
    logic w_unused_status;
    assign w_unused_status = ^i_status;
`endif

    always_comb begin
        ser_d      = ser_q;
        sh_d       = sh_q;
        rem_d      = rem_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        case (ser_q)
            SER_IDLE: begin
                if (i_start) begin
                    sh_d  = w_payload;
                    rem_d = IDX_W'(TOTAL);
                    ser_d = SER_SEND;
                end
            end
            SER_SEND: begin
                tx_data_d  = sh_q[7:0];
                tx_start_d = 1'b1;
                sh_d       = sh_q >> 8;
                rem_d      = rem_q - 1'b1;
                ser_d      = SER_WAIT;
            end
            SER_WAIT: begin
                if (is_tx_done) begin
                    if (rem_q == '0) begin
                        done_d = 1'b1;
                        ser_d  = SER_IDLE;
                    end else begin
                        ser_d  = SER_SEND;
                    end
                end
            end
            default: ser_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_q      <= SER_IDLE;
            sh_q       <= '0;
            rem_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ser_q      <= ser_d;
            sh_q       <= sh_d;
            rem_q      <= rem_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign os_tx_start = tx_start_q;
    assign os_done     = done_q;

endmodule : debug_dump_serializer
`default_nettype wire

// File: rtl/debug_ctrl_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debug_ctrl_gen
// Purpose  : UART-driven debug controller for the pipelined CPU. Decodes host
//            commands: load program memory, free run, run to breakpoint and
//            single step; after each run/step it dumps the pipe snapshot and
//            cycle count through the shared serializer.
// Ports    : clk, rst                 - clock, async active-high reset
//            i_rx_data, is_rx_done    - received UART byte + strobe
//            is_tx_done               - transmitter byte-complete strobe
//            is_stop_pipe, i_pc       - pipe halt flag, current fetch PC
//            i_snapshot               - pipe state to dump
//            o_step                   - pipe clock enable
//            o_address, o_instruction, os_mem_write - program-memory write
//            o_tx_data, os_tx_start   - byte to transmit + start strobe
//            o_reset_pipe             - pipe reset, active-low
//            o_led                    - high while IDLE
// Options  : DBG_RUN_TIMEOUT_EN - run watchdog (TIMEOUT_CYC) and status byte
// Revision : 1.0 - initial release
// ============================================================================
module debug_ctrl_gen
    import debug_ctrl_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int ADDR_W      = 8,
    parameter int SNAP_BYTES  = 320,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic [7:0]              i_rx_data,
    input  wire logic                    is_rx_done,
    input  wire logic                    is_tx_done,
    input  wire logic                    is_stop_pipe,
    input  wire logic [ADDR_W-1:0]       i_pc,
    input  wire logic [SNAP_BYTES*8-1:0] i_snapshot,
    output logic                         o_step,
    output logic [ADDR_W-1:0]            o_address,
    output logic [INSTR_W-1:0]           o_instruction,
    output logic                         os_mem_write,
    output logic [7:0]                   o_tx_data,
    output logic                         os_tx_start,
    output logic                         o_reset_pipe,
    output logic                         o_led
);

    localparam int WORD_BYTES = INSTR_W / 8;

    dbg_state_t          state_q, state_d;
    logic                step_q, step_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                mem_write_q, mem_write_d;
    logic                reset_pipe_q, reset_pipe_d;
    logic                led_q, led_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                brk_en_q, brk_en_d;
    logic [ADDR_W-1:0]   brk_pc_q, brk_pc_d;
    logic [7:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          words_left_q, words_left_d;
    logic                halted_q, halted_d;
    logic                ret_step_q, ret_step_d;

    logic                w_dump_start;
    logic [7:0]          w_dump_status;
    logic                w_dump_done;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_stop;

`ifndef DBG_RUN_TIMEOUT_EN
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // Counter value including the current cycle if the pipe is stepping;
    // saturates rather than wrapping.
    assign w_cnt_inc = (step_q && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        address_d     = address_q;
        instr_d       = instr_q;
        mem_write_d   = 1'b0;
        reset_pipe_d  = reset_pipe_q;
        led_d         = led_q;
        cnt_d         = cnt_q;
        brk_en_d      = brk_en_q;
        brk_pc_d      = brk_pc_q;
        byte_idx_d    = byte_idx_q;
        words_left_d  = words_left_q;
        halted_d      = halted_q | is_stop_pipe;
        ret_step_d    = ret_step_q;
        w_dump_start  = 1'b0;
        w_dump_status = STATUS_OK;
        w_stop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                reset_pipe_d = 1'b0;
                led_d        = 1'b1;
                step_d       = 1'b0;
                if (is_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d      = S_LD_LEN;
                            reset_pipe_d = 1'b1;
                            led_d        = 1'b0;
                        end
                        CMD_RUN: begin
                            state_d      = S_RUN;
                            reset_pipe_d = 1'b1;
                            led_d        = 1'b0;
                            cnt_d        = '0;
                            brk_en_d     = 1'b0;
                            halted_d     = 1'b0;
                            ret_step_d   = 1'b0;
                        end
                        CMD_STEP: begin
                            state_d      = S_STEP_WAIT;
                            reset_pipe_d = 1'b1;
                            led_d        = 1'b0;
                            cnt_d        = '0;
                            halted_d     = 1'b0;
                            ret_step_d   = 1'b1;
                        end
                        CMD_BRK: begin
                            state_d      = S_BRK_ADDR;
                            reset_pipe_d = 1'b1;
                            led_d        = 1'b0;
                            cnt_d        = '0;
                            brk_en_d     = 1'b1;
                            halted_d     = 1'b0;
                            ret_step_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            S_LD_LEN: begin
                if (is_rx_done) begin
                    if (i_rx_data == 8'h00) begin
                        state_d      = S_IDLE;
                        reset_pipe_d = 1'b0;
                        led_d        = 1'b1;
                    end else begin
                        words_left_d = i_rx_data;
                        address_d    = '0;
                        byte_idx_d   = '0;
                        state_d      = S_LD_BYTE;
                    end
                end
            end

            S_LD_BYTE: begin
                if (is_rx_done) begin
                    instr_d[{byte_idx_q, 3'b000} +: 8] = i_rx_data;
                    if (byte_idx_q == 8'(WORD_BYTES - 1)) begin
                        byte_idx_d  = '0;
                        mem_write_d = 1'b1;
                        state_d     = S_LD_WRITE;
                    end else begin
                        byte_idx_d  = byte_idx_q + 1'b1;
                    end
                end
            end

            // The write strobe is high during this state; the address moves
            // on only after it drops so o_address is stable for the write.
            S_LD_WRITE: begin
                address_d    = address_q + 1'b1;
                words_left_d = words_left_q - 1'b1;
                if (words_left_q == 8'd1) begin
                    state_d      = S_IDLE;
                    reset_pipe_d = 1'b0;
                    led_d        = 1'b1;
                end else begin
                    state_d      = S_LD_BYTE;
                end
            end

            S_BRK_ADDR: begin
                if (is_rx_done) begin
                    brk_pc_d = i_rx_data[ADDR_W-1:0];
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                step_d = 1'b1;
                cnt_d  = w_cnt_inc;
                // Halt and breakpoint together still yield one stop/dump.
                w_stop = is_stop_pipe || (brk_en_q && (i_pc == brk_pc_q));
`ifdef DBG_RUN_TIMEOUT_EN
                if (!w_stop && (w_cnt_inc == CNT_W'(TIMEOUT_CYC))) begin
                    w_stop        = 1'b1;
                    w_dump_status = STATUS_TIMEOUT;
                end
`endif
                if (w_stop) begin
                    step_d       = 1'b0;
                    w_dump_start = 1'b1;
                    state_d      = S_DUMP;
                end
            end

            S_STEP_WAIT: begin
                if (is_rx_done) begin
                    if (i_rx_data == STEP_GO) begin
                        // A halted pipe is not clocked again, but still dumps.
                        step_d  = ~(halted_q | is_stop_pipe);
                        state_d = S_STEP_PULSE;
                    end else if (i_rx_data == STEP_EXIT) begin
                        state_d      = S_IDLE;
                        reset_pipe_d = 1'b0;
                        led_d        = 1'b1;
                    end
                end
            end

            S_STEP_PULSE: begin
                step_d       = 1'b0;
                cnt_d        = w_cnt_inc;
                w_dump_start = 1'b1;
                state_d      = S_DUMP;
            end

            S_DUMP: begin
                if (w_dump_done) begin
                    if (ret_step_q) begin
                        state_d = S_STEP_WAIT;
                    end else begin
                        state_d      = S_IDLE;
                        reset_pipe_d = 1'b0;
                        led_d        = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_q       <= 1'b0;
            address_q    <= '0;
            instr_q      <= '0;
            mem_write_q  <= 1'b0;
            reset_pipe_q <= 1'b0;
            led_q        <= 1'b1;
            cnt_q        <= '0;
            brk_en_q     <= 1'b0;
            brk_pc_q     <= '0;
            byte_idx_q   <= '0;
            words_left_q <= '0;
            halted_q     <= 1'b0;
            ret_step_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            address_q    <= address_d;
            instr_q      <= instr_d;
            mem_write_q  <= mem_write_d;
            reset_pipe_q <= reset_pipe_d;
            led_q        <= led_d;
            cnt_q        <= cnt_d;
            brk_en_q     <= brk_en_d;
            brk_pc_q     <= brk_pc_d;
            byte_idx_q   <= byte_idx_d;
            words_left_q <= words_left_d;
            halted_q     <= halted_d;
            ret_step_q   <= ret_step_d;
        end
    end

    // The count handed over is cnt_d so the final stepping cycle is included.
    debug_dump_serializer #(
        .SNAP_BYTES (SNAP_BYTES),
        .CNT_W      (CNT_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_dump_start),
        .i_snapshot  (i_snapshot),
        .i_count     (cnt_d),
        .i_status    (w_dump_status),
        .is_tx_done  (is_tx_done),
        .o_tx_data   (o_tx_data),
        .os_tx_start (os_tx_start),
        .os_done     (w_dump_done)
    );

    assign o_step        = step_q;
    assign o_address     = address_q;
    assign o_instruction = instr_q;
    assign os_mem_write  = mem_write_q;
    assign o_reset_pipe  = reset_pipe_q;
    assign o_led         = led_q;

endmodule : debug_ctrl_gen
`default_nettype wire

// File: doc/debug_ctrl_gen.md
Name: debug_ctrl_gen

Overview:
UART-driven debug controller for the pipelined CPU; the next generation of the debugger top FSM. It decodes host command bytes and supports four modes:
- load program memory (variable word count)
- free run until the pipe halts
- run to a PC breakpoint
- single step
After run, break-run and each step it serializes a parametrised pipe snapshot plus a cycle count back to the UART transmitter.
Load, run, step, break-run and dump are merged into one block with one state machine and one shared serializer.

Parameters:
INSTR_W, 32, program-memory word width; must be a multiple of 8.
ADDR_W, 8, program-memory address width; breakpoint PC width.
SNAP_BYTES, 320, bytes of i_snapshot sent per dump.
CNT_W, 32, cycle-counter width; multiple of 8.
TIMEOUT_CYC, 1000000, watchdog limit (used only with DBG_RUN_TIMEOUT_EN).

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
i_rx_data  in  8  received UART byte
is_rx_done  in  1  one-cycle strobe: i_rx_data valid
is_tx_done  in  1  one-cycle strobe: transmitter finished a byte
is_stop_pipe  in  1  pipe reached halt instruction
i_pc  in  ADDR_W  current fetch PC
i_snapshot  in  SNAP_BYTES*8  pipe register/memory snapshot
o_step  out  1  pipe clock enable
o_address  out  ADDR_W  program-memory write address
o_instruction  out  INSTR_W  program-memory write data
os_mem_write  out  1  program-memory write strobe
o_tx_data  out  8  byte to transmit
os_tx_start  out  1  one-cycle transmit start strobe
o_reset_pipe  out  1  pipe reset, active-low (0 = pipe held in reset)
o_led  out  1  high while IDLE

Behaviour:
- Reset values: all outputs registered. o_step=0, o_address=0, o_instruction=0, os_mem_write=0, o_tx_data=0, os_tx_start=0, o_reset_pipe=0, o_led=1. State = IDLE; cycle counter = 0.
- Reset asserted mid-operation: immediate return to IDLE; any transmission in progress is abandoned.
- IDLE: o_reset_pipe=0. Command is decoded on the is_rx_done byte.
  - 0x01 -> LD_LEN
  - 0x02 -> RUN
  - 0x03 -> STEP_WAIT
  - 0x04 -> BRK_ADDR
  - any other byte ignored; state stays IDLE.
- Leaving IDLE: o_reset_pipe=1 and o_led=0 one cycle after the command byte is sampled. The cycle counter clears on entry to RUN, BRK_ADDR or STEP_WAIT.
- LD_LEN: next rx byte N = word count. N=0 -> IDLE with no writes.
- LD_BYTE: collects INSTR_W/8 bytes, little-endian, into o_instruction.
- LD_WRITE: os_mem_write=1 for exactly one cycle with o_address=k for word k (k = 0 .. N-1). Address wraps at 2^ADDR_W. After word N-1 -> IDLE, and o_reset_pipe returns to 0.
- RUN: o_step=1 on the cycle after entry. The counter increments on every cycle o_step=1 and saturates at all-ones. When is_stop_pipe is sampled high, o_step=0 on the next edge, then DUMP; after DUMP -> IDLE.
- BRK_ADDR: next rx byte (ADDR_W<=8) = breakpoint B. Then behaves as RUN, but also stops when i_pc==B. If the stop and breakpoint conditions occur in the same cycle: single stop, single dump. Breakpoint match on the very first run cycle is honoured.
- STEP_WAIT:
  - rx 0x01: o_step=1 for exactly one cycle, counter +1, then DUMP, then back to STEP_WAIT.
  - rx 0x00: -> IDLE.
  - other bytes ignored.
  - Steps requested after is_stop_pipe was seen still dump, but o_step stays 0.
- DUMP: sends SNAP_BYTES bytes of i_snapshot, LSB byte first, then CNT_W/8 counter bytes, LSB first.
  - Per byte: os_tx_start pulses 1 cycle with o_tx_data valid; the next byte waits for is_tx_done.
  - i_snapshot and the counter are captured into the serializer on DUMP entry, so the pipe may change during transmission.
- rx bytes arriving in RUN, DUMP or LD_WRITE are dropped.

Optional Feature:
DBG_RUN_TIMEOUT_EN:
- Defined: in RUN/break-run, when the counter reaches TIMEOUT_CYC, o_step drops, a status byte 0xEE is sent before the normal dump, and the block returns to IDLE. A normal stop sends status 0x00 first. Dump length becomes 1 + SNAP_BYTES + CNT_W/8.
- Undefined: no watchdog and no status byte; runs are unbounded.

Decomposition:
- Package debug_ctrl_pkg: command opcodes (CMD_LOAD=0x01, CMD_RUN=0x02, CMD_STEP=0x03, CMD_BRK=0x04, STEP_GO=0x01, STEP_EXIT=0x00), status codes (0x00, 0xEE), and the state encoding.
- Sub-module debug_dump_serializer: capture register, byte index counter and tx handshake. Interface: start/done.

Test Plan:
- Load: rx 01, 02, then bytes 78 56 34 12 EF BE AD DE -> two os_mem_write pulses: addr 0 = 0x12345678, addr 1 = 0xDEADBEEF; then IDLE, o_led=1.
- Run: rx 02; assert is_stop_pipe after 50 o_step cycles -> o_step low next edge; SNAP_BYTES snapshot bytes, then counter bytes 32 00 00 00.
- Break-run: rx 04, 0x10; i_pc reaches 0x10 at cycle 7 -> stop, dump with count 7; is_stop_pipe never asserted.
- Step: rx 03, 01, 01, 00 -> two single-cycle o_step pulses, two dumps with counts 1 and 2, then IDLE.
- Robustness: rx 0x7F in IDLE -> no state change. Assert rst mid-dump (byte 5) -> all outputs at reset values immediately, no further os_tx_start.
- DBG_RUN_TIMEOUT_EN with TIMEOUT_CYC=100: rx 02, no stop -> o_step low after 100 cycles; first tx byte 0xEE.
